ram_req_arbiter: RTL and testbench

- Sits on the clk100m side between the write FIFO (addr+data), the read-address FIFO and ram_controller.
- Replaces the shared "pop on busy" hookup: grants one request at a time, round-robin between write and read, and pops only the granted FIFO.
- Holds the controller enable until the controller acknowledges with busy, then waits for busy to drop.
- A bounded acknowledge timeout prevents lock-up.

---
 rtl/ram_req_arbiter.sv | 80 ++++++++
 tb/tb_ram_req_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_arbiter.sv
// ram_req_arbiter: round-robin write/read request arbiter in front of ram_controller; RAM_ARB_STATS_EN adds grant counters
module ram_req_arbiter #(
  parameter int HADDR_WIDTH = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_empty_n,
  input  logic [HADDR_WIDTH+DATA_WIDTH-1:0] wr_head,
  output logic                              wr_pop,
  input  logic                              rd_empty_n,
  input  logic [HADDR_WIDTH-1:0]            rd_head,
  output logic                              rd_pop,
  input  logic                              ctrl_busy,
  output logic                              ctrl_wr_enable,
  output logic [HADDR_WIDTH-1:0]            ctrl_wr_addr,
  output logic [DATA_WIDTH-1:0]             ctrl_wr_data,
  output logic                              ctrl_rd_enable,
  output logic [HADDR_WIDTH-1:0]            ctrl_rd_addr,
`ifdef RAM_ARB_STATS_EN
  output logic [15:0]                       wr_grant_cnt,
  output logic [15:0]                       rd_grant_cnt,
`endif
  output logic                              timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
  state_t state, state_nx;
  logic cur_rd, last_rd, pick_rd, grant, timeout;
  logic [7:0] cnt;
  // arbitration choice, next state and request strobes
  always_comb begin
    pick_rd = rd_empty_n && !(wr_empty_n && last_rd);
    grant = state == IDLE && !ctrl_busy && (wr_empty_n || rd_empty_n);
    timeout = state == ISSUE && !ctrl_busy && cnt == TO_LAST;
    state_nx = state == IDLE  ? (grant ? ISSUE : IDLE) :
               state == ISSUE ? (ctrl_busy ? WAIT : timeout ? IDLE : ISSUE) :
               state == WAIT  ? (ctrl_busy ? WAIT : IDLE) : IDLE;
    ctrl_wr_enable = state == ISSUE && !cur_rd;
    ctrl_rd_enable = state == ISSUE && cur_rd;
    wr_pop = ctrl_wr_enable && cnt == 8'd0;
    rd_pop = ctrl_rd_enable && cnt == 8'd0;
  end
  // state, head latches, saturating ack counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_rd <= 1'b1;
      cur_rd <= 1'b0;
      cnt <= '0;
      ctrl_wr_addr <= '0;
      ctrl_wr_data <= '0;
      ctrl_rd_addr <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        cur_rd <= pick_rd;
        last_rd <= pick_rd;
        cnt <= '0;
        if (pick_rd) ctrl_rd_addr <= rd_head;
        else {ctrl_wr_addr, ctrl_wr_data} <= wr_head;
      end else if (state == ISSUE && cnt != 8'hFF) cnt <= cnt + 8'd1;
      if (timeout) timeout_err <= 1'b1;
    end
  end
`ifdef RAM_ARB_STATS_EN
  // count acknowledged requests of each type
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_grant_cnt <= '0;
      rd_grant_cnt <= '0;
    end else if (state == ISSUE && ctrl_busy) begin
      if (cur_rd) rd_grant_cnt <= rd_grant_cnt + 16'd1;
      else wr_grant_cnt <= wr_grant_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ram_req_arbiter.sv
// tb_ram_req_arbiter: scoreboard bench for ram_req_arbiter grant order, handshake, timeout and reset
module tb_ram_req_arbiter;
  typedef struct {bit rd; logic [23:0] addr; logic [15:0] data;} ent_t;
  logic clk = 0, rst = 1, wr_empty_n = 0, rd_empty_n = 0, ctrl_busy = 0;
  logic [39:0] wr_head = '0;
  logic [23:0] rd_head = '0;
  logic wr_pop, rd_pop, ctrl_wr_enable, ctrl_rd_enable, timeout_err;
  logic [23:0] ctrl_wr_addr, ctrl_rd_addr;
  logic [15:0] ctrl_wr_data;
`ifdef RAM_ARB_STATS_EN
  logic [15:0] wr_grant_cnt, rd_grant_cnt;
`endif
  logic [39:0] wr_q[$];
  logic [23:0] rd_q[$];
  ent_t exp_q[$];
  int checks = 0, errors = 0, acked_wr = 0, acked_rd = 0;
  bit auto_ack = 0;
  always #5 clk = ~clk;
  ram_req_arbiter dut (
    .clk(clk), .rst(rst), .wr_empty_n(wr_empty_n), .wr_head(wr_head), .wr_pop(wr_pop),
    .rd_empty_n(rd_empty_n), .rd_head(rd_head), .rd_pop(rd_pop), .ctrl_busy(ctrl_busy),
    .ctrl_wr_enable(ctrl_wr_enable), .ctrl_wr_addr(ctrl_wr_addr), .ctrl_wr_data(ctrl_wr_data),
    .ctrl_rd_enable(ctrl_rd_enable), .ctrl_rd_addr(ctrl_rd_addr),
`ifdef RAM_ARB_STATS_EN
    .wr_grant_cnt(wr_grant_cnt), .rd_grant_cnt(rd_grant_cnt),
`endif
    .timeout_err(timeout_err));

  task automatic drive_fifos();
    wr_empty_n = wr_q.size() != 0;
    wr_head = wr_q.size() != 0 ? wr_q[0] : '0;
    rd_empty_n = rd_q.size() != 0;
    rd_head = rd_q.size() != 0 ? rd_q[0] : '0;
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [15:0] d);
    wr_q.push_back({a, d});
    exp_q.push_back('{rd: 0, addr: a, data: d});
  endtask

  task automatic push_rd(input logic [23:0] a);
    rd_q.push_back(a);
    exp_q.push_back('{rd: 1, addr: a, data: 16'h0});
  endtask

  task automatic step();
    ent_t e;
    logic [40:0] got, want;
    if (!rst && ctrl_wr_enable && ctrl_busy) acked_wr++;
    if (!rst && ctrl_rd_enable && ctrl_busy) acked_rd++;
    @(posedge clk);
    #1;
    if (rst) begin acked_wr = 0; acked_rd = 0; end
    checks++;
    if (ctrl_wr_enable && ctrl_rd_enable) begin
      errors++;
      $display("FAIL both_enables got wr=%b rd=%b required not both 1", ctrl_wr_enable, ctrl_rd_enable);
    end
    if (wr_pop || rd_pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant got wr_pop=%b rd_pop=%b required no grant", wr_pop, rd_pop);
      end else begin
        e = exp_q.pop_front();
        got = {rd_pop & ~wr_pop, rd_pop ? ctrl_rd_addr : ctrl_wr_addr, rd_pop ? 16'h0 : ctrl_wr_data};
        want = {e.rd, e.addr, e.data};
        if (got !== want) begin
          errors++;
          $display("FAIL grant got rd=%b addr=%h data=%h required rd=%b addr=%h data=%h",
                   got[40], got[39:16], got[15:0], want[40], want[39:16], want[15:0]);
        end
      end
      if (wr_pop && wr_q.size() != 0) wr_q.delete(0);
      if (rd_pop && rd_q.size() != 0) rd_q.delete(0);
    end
    if (auto_ack) ctrl_busy = ctrl_wr_enable || ctrl_rd_enable;
    drive_fifos();
  endtask

  task automatic test_reset();
    push_wr(24'h001234, 16'hBEEF);
    push_rd(24'h00ABCD);
    drive_fifos();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({wr_pop, rd_pop, ctrl_wr_enable, ctrl_rd_enable, ctrl_wr_addr, ctrl_wr_data, ctrl_rd_addr, timeout_err} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got pops=%b%b en=%b%b wa=%h wd=%h ra=%h to=%b required all 0",
                 wr_pop, rd_pop, ctrl_wr_enable, ctrl_rd_enable, ctrl_wr_addr, ctrl_wr_data, ctrl_rd_addr, timeout_err);
      end
    end
    rst = 0;
    step();
    checks++;
    if (wr_pop !== 1'b1 || rd_pop !== 1'b0) begin
      errors++;
      $display("FAIL first_grant got wr_pop=%b rd_pop=%b required 1 0", wr_pop, rd_pop);
    end
  endtask

  task automatic test_single_write();
    int en = 1, pops = 0;
    step();
    en += ctrl_wr_enable;
    ctrl_busy = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      en += ctrl_wr_enable;
      pops += wr_pop + rd_pop;
    end
    checks++;
    if (en != 2 || pops != 0) begin
      errors++;
      $display("FAIL single_write_handshake got en_cycles=%0d pops=%0d required 2 0", en, pops);
    end
    checks++;
    if (ctrl_wr_addr !== 24'h001234 || ctrl_wr_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_write_regs got %h/%h required 001234/beef", ctrl_wr_addr, ctrl_wr_data);
    end
    ctrl_busy = 0;
    step();
    checks++;
    if (rd_pop !== 1'b0) begin
      errors++;
      $display("FAIL early_grant got rd_pop=%b required 0", rd_pop);
    end
    step();
    checks++;
    if (rd_pop !== 1'b1) begin
      errors++;
      $display("FAIL read_after_busy got rd_pop=%b required 1", rd_pop);
    end
    ctrl_busy = ctrl_rd_enable;
    auto_ack = 1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_fairness();
    for (int i = 0; i < 4; i++) begin
      push_wr(24'h100000 + 24'(i), 16'hA000 + 16'(i));
      push_rd(24'h200000 + 24'(i));
    end
    drive_fifos();
    auto_ack = 1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fairness_drain got %0d pending required 0", exp_q.size());
    end
`ifdef RAM_ARB_STATS_EN
    checks++;
    if (wr_grant_cnt !== 16'(acked_wr) || rd_grant_cnt !== 16'(acked_rd)) begin
      errors++;
      $display("FAIL stats got wr=%0d rd=%0d required wr=%0d rd=%0d", wr_grant_cnt, rd_grant_cnt, acked_wr, acked_rd);
    end
`endif
  endtask

  task automatic test_timeout();
    int n = 1;
    auto_ack = 0;
    ctrl_busy = 0;
    push_rd(24'h0000AA);
    push_rd(24'h0000BB);
    drive_fifos();
    for (int i = 0; i < 10 && !rd_pop; i++) step();
    checks++;
    if (rd_pop !== 1'b1) begin
      errors++;
      $display("FAIL timeout_grant got rd_pop=%b required 1 within 10 cycles", rd_pop);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (!ctrl_rd_enable) break;
      n++;
    end
    checks++;
    if (n != 15 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout got en_cycles=%0d err=%b required 15 1", n, timeout_err);
    end
    auto_ack = 1;
    step();
    checks++;
    if (rd_pop !== 1'b1 || ctrl_rd_addr !== 24'h0000BB) begin
      errors++;
      $display("FAIL after_timeout got rd_pop=%b addr=%h required 1 0000bb", rd_pop, ctrl_rd_addr);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b required 1", timeout_err);
    end
  endtask

  task automatic test_busy_idle();
    int act = 0;
    auto_ack = 0;
    ctrl_busy = 1;
    push_wr(24'h00C0DE, 16'h5A5A);
    drive_fifos();
    for (int i = 0; i < 20; i++) begin
      step();
      act += wr_pop + rd_pop + ctrl_wr_enable + ctrl_rd_enable;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL busy_blocks got activity=%0d required 0", act);
    end
    ctrl_busy = 0;
    step();
    checks++;
    if (wr_pop !== 1'b1) begin
      errors++;
      $display("FAIL grant_after_busy got wr_pop=%b required 1", wr_pop);
    end
    ctrl_busy = 1;
    auto_ack = 1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset_mid();
    int pops = 0;
    auto_ack = 0;
    ctrl_busy = 0;
    push_wr(24'h00D00D, 16'h1111);
    push_wr(24'h00E00E, 16'h2222);
    drive_fifos();
    for (int i = 0; i < 10 && !wr_pop; i++) step();
    ctrl_busy = 1;
    step();
    step();
`ifdef RAM_ARB_STATS_EN
    checks++;
    if (wr_grant_cnt !== 16'(acked_wr) || wr_grant_cnt == 16'd0) begin
      errors++;
      $display("FAIL stats_before_reset got %0d required %0d nonzero", wr_grant_cnt, acked_wr);
    end
`endif
    rst = 1;
    step();
    pops += wr_pop + rd_pop;
    checks++;
    if ({ctrl_wr_enable, ctrl_rd_enable, timeout_err, ctrl_wr_addr, ctrl_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid got en=%b%b to=%b wa=%h wd=%h required all 0",
               ctrl_wr_enable, ctrl_rd_enable, timeout_err, ctrl_wr_addr, ctrl_wr_data);
    end
`ifdef RAM_ARB_STATS_EN
    checks++;
    if (wr_grant_cnt !== 16'd0 || rd_grant_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset got wr=%0d rd=%0d required 0 0", wr_grant_cnt, rd_grant_cnt);
    end
`endif
    step();
    pops += wr_pop + rd_pop;
    checks++;
    if (pops != 0 || wr_q.size() != 1) begin
      errors++;
      $display("FAIL reset_no_pop got pops=%0d fifo=%0d required 0 1", pops, wr_q.size());
    end
    rst = 0;
    ctrl_busy = 0;
    auto_ack = 1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL reset_resume got pending=%0d fifo=%0d required 0 0", exp_q.size(), wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_timeout();
    test_busy_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
